// File: rtl/rf_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_arb_pkg : shared types and default sizes for the register-file arbiter    |
// | Revision   : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rf_arb_pkg;

  localparam int c_n_req  = 2;
  localparam int c_addr_w = 3;
  localparam int c_data_w = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rf_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_arb_pick : winner selection; round-robin when RF_ARB_RR_EN is defined,     |
// |               otherwise fixed priority with the lowest index winning        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module rf_arb_pick
  import rf_arb_pkg::*;
#(
  parameter int N_REQ = c_n_req,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx
);

`ifdef RF_ARB_RR_EN
  // Walk from farthest to nearest so the requester just after i_last wins.
  always_comb begin : p_rr
    int                 v_j;
    logic [IDX_W-1:0]   v_idx;
    o_idx = '0;
    v_j   = 0;
    v_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      v_j   = (int'(i_last) + k) % N_REQ;
      v_idx = IDX_W'(v_j);
      if (i_req[v_idx]) begin
        o_idx = v_idx;
      end
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  always_comb begin : p_fixed
    o_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[IDX_W'(k)]) begin
        o_idx = IDX_W'(k);
      end
    end
  end
`endif

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_onehot
      assign o_onehot[g] = i_req[g] && (o_idx == IDX_W'(g));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_arb   : arbitrates N_REQ requesters onto one register-file port           |
// |            (define RF_ARB_RR_EN for round-robin, else fixed priority)        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module rf_arb
  import rf_arb_pkg::*;
#(
  parameter int N_REQ  = c_n_req,
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         WR,
  input  logic [N_REQ*ADDR_W-1:0]  ADDR,
  input  logic [N_REQ*DATA_W-1:0]  WDATA,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         RVALID,
  output logic [DATA_W-1:0]        RDATA,
  output logic                     RF_WEN,
  output logic                     RF_OEN,
  output logic [ADDR_W-1:0]        RF_ADDR,
  output logic [DATA_W-1:0]        RF_DIN,
  input  logic [DATA_W-1:0]        RF_DOUT
);

  localparam int c_idx_w = $clog2(N_REQ);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [N_REQ-1:0]     r_gnt,    w_gnt_nxt;
  logic [N_REQ-1:0]     r_rvalid, w_rvalid_nxt;
  logic [DATA_W-1:0]    r_rdata,  w_rdata_nxt;
  logic                 r_wen,    w_wen_nxt;
  logic                 r_oen,    w_oen_nxt;
  logic [ADDR_W-1:0]    r_addr,   w_addr_nxt;
  logic [DATA_W-1:0]    r_din,    w_din_nxt;
  logic [c_idx_w-1:0]   r_win,    w_win_nxt;

  logic [N_REQ-1:0]     w_pick_oh;
  logic [c_idx_w-1:0]   w_pick_idx;
  logic [c_idx_w-1:0]   w_last;
  logic                 w_grant;

  logic [ADDR_W-1:0]    w_addr_arr  [N_REQ];
  logic [DATA_W-1:0]    w_wdata_arr [N_REQ];

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_addr_arr[g]  = ADDR[g*ADDR_W +: ADDR_W];
      assign w_wdata_arr[g] = WDATA[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_grant = (r_state == IDLE) && (|REQ);

  rf_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (c_idx_w)
  ) u_pick (
    .i_req    (REQ),
    .i_last   (w_last),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx)
  );

`ifdef RF_ARB_RR_EN
  logic [c_idx_w-1:0] r_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last <= c_idx_w'(N_REQ - 1);
    end else if (w_grant) begin
      r_last <= w_pick_idx;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = c_idx_w'(N_REQ - 1);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = '0;
    w_rvalid_nxt = '0;
    w_wen_nxt    = 1'b0;
    w_oen_nxt    = 1'b0;
    w_rdata_nxt  = r_rdata;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_win_nxt    = r_win;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = ACCESS;
          w_gnt_nxt   = w_pick_oh;
          w_addr_nxt  = w_addr_arr[w_pick_idx];
          w_din_nxt   = w_wdata_arr[w_pick_idx];
          w_wen_nxt   = WR[w_pick_idx];
          w_oen_nxt   = ~WR[w_pick_idx];
          w_win_nxt   = w_pick_idx;
        end
      end
      // r_oen still marks the access type during the single ACCESS cycle.
      ACCESS: begin
        w_state_nxt = r_oen ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        w_state_nxt         = IDLE;
        w_rdata_nxt         = RF_DOUT;
        w_rvalid_nxt[r_win] = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_wen    <= 1'b0;
      r_oen    <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_win    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
      r_wen    <= w_wen_nxt;
      r_oen    <= w_oen_nxt;
      r_addr   <= w_addr_nxt;
      r_din    <= w_din_nxt;
      r_win    <= w_win_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RF_WEN  = r_wen;
  assign RF_OEN  = r_oen;
  assign RF_ADDR = r_addr;
  assign RF_DIN  = r_din;

endmodule
`default_nettype wire
